// File: rtl/nibble_add_seq.sv
// -----------------------------------------------------------------------------
// nibble_add_seq
//
// Multi-cycle WIDTH-bit adder sequencer. It feeds an external combinational
// 4-bit add unit one nibble per cycle, LSB first. The carry out of each nibble
// is registered and fed back as the carry into the next nibble.
//
// Flow: IDLE accepts an operand pair. RUN takes NIB cycles, one nibble each.
// DONE presents the result until the consumer takes it.
//
// Ports
//   clk, rst_n            clock; synchronous active-low reset
//   in_valid / in_ready   operand handshake (in_a, in_b, in_cin)
//   add_a, add_b, add_cin nibble operands and carry driven to the add unit
//   add_sum, add_cout     add unit result (combinational, same cycle)
//   out_valid / out_ready result handshake (out_sum, out_cout, out_ovf)
//
// Parameter
//   WIDTH  operand width; must be a multiple of 4 and at least 4
// -----------------------------------------------------------------------------
module nibble_add_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic [3:0]       add_a,
    output logic [3:0]       add_b,
    output logic             add_cin,
    input  logic [3:0]       add_sum,
    input  logic             add_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int NIB  = WIDTH / 4;
    localparam int CNTW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CNTW-1:0] LAST_CNT = CNTW'(NIB - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_reg;
    state_t            state_next;
    logic [WIDTH-1:0]  a_reg;
    logic [WIDTH-1:0]  b_reg;
    logic              carry_reg;
    logic [CNTW-1:0]   cnt_reg;
    logic              cout_reg;
    logic              ovf_reg;
    logic              last_nib;

    // Nibble views of the captured operands. Indexing them by the counter
    // gives the add unit operands without a variable part-select.
    logic [3:0] a_nib [NIB];
    logic [3:0] b_nib [NIB];

    assign last_nib = (cnt_reg == LAST_CNT);

    // Each result nibble has its own register. The register loads only on
    // the RUN cycle whose counter value matches its position.
    generate
        for (genvar gi = 0; gi < NIB; gi++) begin : g_nib
            localparam logic [CNTW-1:0] NIB_IDX = CNTW'(gi);
            logic [3:0] sum_nib_reg;

            assign a_nib[gi] = a_reg[4*gi +: 4];
            assign b_nib[gi] = b_reg[4*gi +: 4];
            assign out_sum[4*gi +: 4] = sum_nib_reg;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    sum_nib_reg <= 4'd0;
                end else if (state_reg == RUN && cnt_reg == NIB_IDX) begin
                    sum_nib_reg <= add_sum;
                end
            end
        end
    endgenerate

    // Next-state logic and handshake/add-unit outputs.
    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        add_a      = 4'd0;
        add_b      = 4'd0;
        add_cin    = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                add_a   = a_nib[cnt_reg];
                add_b   = b_nib[cnt_reg];
                add_cin = carry_reg;
                if (last_nib) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, operand capture, carry chain and final flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b0;
            cnt_reg   <= '0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        a_reg     <= in_a;
                        b_reg     <= in_b;
                        carry_reg <= in_cin;
                        cnt_reg   <= '0;
                    end
                end
                RUN: begin
                    carry_reg <= add_cout;
                    if (last_nib) begin
                        // The sign of the result is bit 3 of the top nibble.
                        // Signed overflow means both operands had the same
                        // sign and the result sign differs from it.
                        cout_reg <= add_cout;
                        ovf_reg  <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                                    (add_sum[3] != a_reg[WIDTH-1]);
                        // Reset explicitly so a non-power-of-two NIB can
                        // never leave the counter past the last nibble.
                        cnt_reg  <= '0;
                    end else begin
                        cnt_reg  <= cnt_reg + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign out_cout = cout_reg;
    assign out_ovf  = ovf_reg;

endmodule

// File: tb/tb_nibble_add_seq.sv
module tb_nibble_add_seq;

    localparam int W   = 16;
    localparam int NIB = W / 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          in_valid, in_ready, in_cin;
    logic [W-1:0]  in_a, in_b;
    logic [3:0]    add_a, add_b, add_sum;
    logic          add_cin, add_cout;
    logic          out_valid, out_ready, out_cout, out_ovf;
    logic [W-1:0]  out_sum;

    // WIDTH=4 instance signals.
    logic          w4_in_valid, w4_in_ready, w4_in_cin;
    logic [3:0]    w4_in_a, w4_in_b;
    logic [3:0]    w4_add_a, w4_add_b, w4_add_sum;
    logic          w4_add_cin, w4_add_cout;
    logic          w4_out_valid, w4_out_ready, w4_out_cout, w4_out_ovf;
    logic [3:0]    w4_out_sum;

    nibble_add_seq #(.WIDTH(W)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf)
    );

    nibble_add_seq #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(w4_in_valid), .in_ready(w4_in_ready),
        .in_a(w4_in_a), .in_b(w4_in_b), .in_cin(w4_in_cin),
        .add_a(w4_add_a), .add_b(w4_add_b), .add_cin(w4_add_cin),
        .add_sum(w4_add_sum), .add_cout(w4_add_cout),
        .out_valid(w4_out_valid), .out_ready(w4_out_ready),
        .out_sum(w4_out_sum), .out_cout(w4_out_cout), .out_ovf(w4_out_ovf)
    );

    // Combinational 4-bit add units.
    assign {add_cout, add_sum}       = {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_cin};
    assign {w4_add_cout, w4_add_sum} = {1'b0, w4_add_a} + {1'b0, w4_add_b} + {4'd0, w4_add_cin};

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
        end
    endtask

    // ---------------- behavioural model (16-bit instance) ----------------
    // Transaction-level view: idle, busy for NIB cycles, then holding a result.
    bit           m_busy  = 1'b0;
    bit           m_valid = 1'b0;
    int           m_left  = 0;
    logic [W-1:0] m_a, m_b;
    logic         m_cin;
    logic [W:0]   m_res;
    logic         m_ovf;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_busy  = 1'b0;
            m_valid = 1'b0;
            m_left  = 0;
        end else if (m_valid) begin
            if (out_ready) m_valid = 1'b0;
        end else if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
                m_busy  = 1'b0;
                m_valid = 1'b1;
            end
        end else if (in_valid) begin
            m_a    = in_a;
            m_b    = in_b;
            m_cin  = in_cin;
            m_res  = {1'b0, in_a} + {1'b0, in_b} + {{W{1'b0}}, in_cin};
            m_ovf  = (in_a[W-1] == in_b[W-1]) && (m_res[W-1] != in_a[W-1]);
            m_busy = 1'b1;
            m_left = NIB;
        end
    end

    // Compare process: checks every cycle, 1 time unit after the rising edge.
    always begin : cmp
        int          k;
        int unsigned mask, low;
        @(posedge clk);
        #1;
        if (cmp_en) begin
            chk("in_ready", 32'(in_ready), 32'(!m_busy && !m_valid));
            chk("out_valid", 32'(out_valid), 32'(m_valid));
            if (m_valid) begin
                chk("out_sum", 32'(out_sum), 32'(m_res[W-1:0]));
                chk("out_cout", 32'(out_cout), 32'(m_res[W]));
                chk("out_ovf", 32'(out_ovf), 32'(m_ovf));
            end
            if (m_busy) begin
                k    = NIB - m_left;
                mask = (32'd1 << (4 * k)) - 32'd1;
                low  = (32'(m_a) & mask) + (32'(m_b) & mask) + 32'(m_cin);
                chk("add_a", 32'(add_a), (32'(m_a) >> (4 * k)) & 32'hF);
                chk("add_b", 32'(add_b), (32'(m_b) >> (4 * k)) & 32'hF);
                chk("add_cin", 32'(add_cin), (low >> (4 * k)) & 32'd1);
            end else begin
                chk("add_idle", {23'd0, add_a, add_b, add_cin}, 32'd0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input bit rnd, output int lat);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("in_ready_timeout", 32'(in_ready), 32'd1);
        in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            if (rnd) begin
                in_valid  = 1'($urandom_range(0, 1));
                in_a      = W'($urandom);
                out_ready = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            lat++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        if (lat >= 50) chk("out_valid_timeout", 32'(out_valid), 32'd1);
    endtask

    task automatic hold_done(input int n, input bit pulse);
        for (int i = 0; i < n; i++) begin
            out_ready = 1'b0;
            in_valid  = pulse ? 1'($urandom_range(0, 1)) : 1'b0;
            in_a      = W'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic release_out();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic send4(input string name, input logic [3:0] a, input logic [3:0] b,
                         input logic cin, input logic [3:0] es, input logic ec);
        int lat = 0;
        w4_in_a = a; w4_in_b = b; w4_in_cin = cin; w4_in_valid = 1'b1;
        @(negedge clk);
        w4_in_valid = 1'b0;
        while (!w4_out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({name, "_lat"}, 32'(lat), 32'd1);
        chk({name, "_sum"}, 32'(w4_out_sum), 32'(es));
        chk({name, "_cout"}, 32'(w4_out_cout), 32'(ec));
        w4_out_ready = 1'b1;
        @(negedge clk);
        w4_out_ready = 1'b0;
        chk({name, "_idle"}, 32'(w4_in_ready), 32'd1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int lat;
        rst_n = 1'b0;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b0;
        w4_in_valid = 1'b0; w4_in_a = '0; w4_in_b = '0; w4_in_cin = 1'b0; w4_out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_sum", 32'(out_sum), 32'd0);
        chk("rst_out_flags", {30'd0, out_cout, out_ovf}, 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        rst_n  = 1'b1;
        cmp_en = 1'b1;
        @(negedge clk);

        // Directed cases with hand-computed results.
        send(16'h0006, 16'h0003, 1'b0, 1'b0, lat);
        chk("t1_lat", 32'(lat), 32'd4);
        chk("t1_sum", 32'(out_sum), 32'h0009);
        chk("t1_flags", {30'd0, out_cout, out_ovf}, 32'd0);
        release_out();
        chk("t1_idle_next", 32'(in_ready), 32'd1);

        send(16'hFFFF, 16'h0001, 1'b1, 1'b0, lat);
        chk("t2_sum", 32'(out_sum), 32'h0001);
        chk("t2_flags", {30'd0, out_cout, out_ovf}, 32'd2);
        release_out();

        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, lat);
        chk("t3_sum", 32'(out_sum), 32'h8000);
        chk("t3_flags", {30'd0, out_cout, out_ovf}, 32'd1);
        release_out();

        send(16'h8000, 16'h8000, 1'b0, 1'b0, lat);
        hold_done(5, 1'b1);
        chk("t4_held_valid", 32'(out_valid), 32'd1);
        chk("t4_held_sum", 32'(out_sum), 32'h0000);
        chk("t4_flags", {30'd0, out_cout, out_ovf}, 32'd3);
        release_out();
        chk("t4_idle_next", 32'(in_ready), 32'd1);

        // Reset during RUN at cnt=2.
        in_a = 16'hAAAA; in_b = 16'h5555; in_cin = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk("rst_mid_no_valid", 32'(out_valid), 32'd0);
            @(negedge clk);
        end
        send(16'h1234, 16'h1111, 1'b0, 1'b0, lat);
        chk("t5_sum", 32'(out_sum), 32'h2345);
        release_out();

        // WIDTH=4 instance.
        send4("w4_a", 4'b0110, 4'b0011, 1'b0, 4'b1001, 1'b0);
        send4("w4_b", 4'b1111, 4'b0001, 1'b1, 4'b0001, 1'b1);

        // Randomized operations checked by the model.
        for (int t = 0; t < 150; t++) begin
            logic [W-1:0] a, b;
            a = W'($urandom);
            b = W'($urandom);
            case ($urandom_range(0, 3))
                0: a = 16'hFFFF;
                1: b = 16'h8000 | W'($urandom_range(0, 15));
                default: ;
            endcase
            send(a, b, 1'($urandom_range(0, 1)), 1'b1, lat);
            chk("rnd_lat", 32'(lat), 32'd4);
            hold_done(int'($urandom_range(0, 4)), 1'b1);
            release_out();
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog_timeout got=running exp=finished");
        $fatal(1, "watchdog");
    end

endmodule
